// File: rtl/mul_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// mul_accumulator_pkg
//   Shared definitions for the multiply-accumulate result collector:
//   - state_t   : FSM state encoding (IDLE=0, ACCUM=1, HOLD=2)
//   - ACC_W_DEF : default accumulator width (must be >= 64)
//   - CNT_W_DEF : default product-counter width
//   - ACC_MAX / ACC_MIN : saturation limits for the default accumulator width
//   - sat_limit(): builds the saturation limit for any width up to ACC_W_DEF
// ---------------------------------------------------------------------------
package mul_accumulator_pkg;

    localparam int ACC_W_DEF = 72;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Largest / smallest signed values representable in ACC_W_DEF bits.
    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Saturation limit for a width w (w <= ACC_W_DEF), returned right-aligned
    // in an ACC_W_DEF-bit word: the positive limit is 2^(w-1)-1, the negative
    // limit is -2^(w-1) truncated to w bits.
    function automatic logic [ACC_W_DEF-1:0] sat_limit(input int w, input logic neg);
        logic [ACC_W_DEF-1:0] lim;
        lim = ACC_MAX >> (ACC_W_DEF - w);
        if (neg) begin
            lim = ACC_MIN >> (ACC_W_DEF - w);
        end
        return lim;
    endfunction

endpackage

// File: rtl/mul_accumulator_if.sv
// ---------------------------------------------------------------------------
// mul_accumulator_if
//   Product input channel and batch result channel of the accumulator.
//   Product channel : prod_valid/prod_ready, prod_data (signed 64), prod_ovf,
//                     prod_last (final product of the batch).
//   Result channel  : res_valid/res_ready, res_data (signed ACC_W),
//                     res_count (CNT_W), res_ovf (sticky overflow).
//   Modports:
//     slave  - the accumulator (consumes products, produces results)
//     master - the environment (produces products, consumes results)
// ---------------------------------------------------------------------------
interface mul_accumulator_if #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 16
);
    logic             prod_valid;
    logic             prod_ready;
    logic [63:0]      prod_data;
    logic             prod_ovf;
    logic             prod_last;

    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    modport slave (
        input  prod_valid, prod_data, prod_ovf, prod_last, res_ready,
        output prod_ready, res_valid, res_data, res_count, res_ovf
    );

    modport master (
        output prod_valid, prod_data, prod_ovf, prod_last, res_ready,
        input  prod_ready, res_valid, res_data, res_count, res_ovf
    );

endinterface

// File: rtl/mul_acc_adder.sv
// ---------------------------------------------------------------------------
// mul_acc_adder
//   Combinational datapath of the accumulator: sign-extends a signed 64-bit
//   product to ACC_W bits, adds it to the running sum and flags signed-add
//   overflow (operands share a sign, result sign differs).
//   Optional: with MUL_ACCUMULATOR_SATURATE_EN defined, an overflowing sum is
//   clamped to the most positive / most negative ACC_W-bit value; otherwise it
//   wraps in two's complement and no clamp logic exists.
//   Ports:
//     acc_in  - current accumulator value (signed, ACC_W)
//     prod    - product (signed, 64)
//     sum_out - new accumulator value (signed, ACC_W)
//     add_ovf - signed-add overflow of this addition
// ---------------------------------------------------------------------------
module mul_acc_adder
    import mul_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [63:0]      prod,
    output logic [ACC_W-1:0] sum_out,
    output logic             add_ovf
);

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] raw_sum;

    // Sign extension: replicate the product MSB into the upper bits. With
    // ACC_W == 64 the loop is empty and the product is used as is.
    assign prod_ext[63:0] = prod;
    generate
        for (genvar gi = 64; gi < ACC_W; gi++) begin : g_sext
            assign prod_ext[gi] = prod[63];
        end
    endgenerate

    assign raw_sum = acc_in + prod_ext;
    assign add_ovf = (acc_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (raw_sum[ACC_W-1] != acc_in[ACC_W-1]);

`ifdef MUL_ACCUMULATOR_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow both operands had the same sign, so the accumulator MSB
    // tells which rail was crossed.
    always_comb begin
        sum_out = raw_sum;
        if (add_ovf) begin
            sum_out = acc_in[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum_out = raw_sum;
`endif

endmodule

// File: rtl/mul_accumulator.sv
// ---------------------------------------------------------------------------
// mul_accumulator
//   Collects signed 64-bit products from the multiplier through a valid/ready
//   handshake and sums them into a wide signed accumulator. The batch ends
//   with a product flagged prod_last; the sum, product count and sticky
//   overflow are then held on the result channel until res_ready.
//   Optional feature macro: MUL_ACCUMULATOR_SATURATE_EN (clamp on overflow).
//   Parameters:
//     ACC_W - accumulator / result width (>= 64)
//     CNT_W - product counter width (saturating)
//   Ports:
//     clk       - rising-edge clock
//     reset     - synchronous, active-high
//     acc_clear - discard the running sum (ignored while holding a result)
//     busy      - high in ACCUM or HOLD
//     bus       - product and result channels (mul_accumulator_if.slave)
// ---------------------------------------------------------------------------
module mul_accumulator
    import mul_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_clear,
    output logic             busy,
    mul_accumulator_if.slave bus
);

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;

    logic             accept;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             ovf_base;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    // prod_ready is a pure decode of the state register, so it never depends
    // combinationally on res_ready.
    assign bus.prod_ready = (state_reg != HOLD);
    assign accept         = bus.prod_valid & bus.prod_ready;

    // acc_clear together with an accept means "start over with this product":
    // the add operates on a zeroed accumulator.
    assign acc_base = acc_clear ? '0 : acc_reg;
    assign cnt_base = acc_clear ? '0 : cnt_reg;
    assign ovf_base = acc_clear ? 1'b0 : ovf_reg;

    assign cnt_inc = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

    mul_acc_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .acc_in  (acc_base),
        .prod    (bus.prod_data),
        .sum_out (add_sum),
        .add_ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_next   = add_sum;
                    cnt_next   = cnt_inc;
                    ovf_next   = ovf_base | bus.prod_ovf | add_ovf;
                    state_next = bus.prod_last ? HOLD : ACCUM;
                end else if (acc_clear) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                // Result registers stay frozen until the consumer takes them.
                if (bus.res_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.res_valid = (state_reg == HOLD);
    assign bus.res_data  = acc_reg;
    assign bus.res_count = cnt_reg;
    assign bus.res_ovf   = ovf_reg;
    assign busy          = (state_reg != IDLE);

endmodule
